sn_to_bn: RTL and testbench



---
 rtl/sn_to_bn.sv | 111 +++++++++++
 tb/tb_sn_to_bn.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sn_to_bn.sv
// Stochastic-to-binary decoder: counts ones in a fixed-length unipolar stream
// and returns the full-precision count plus a saturated binary magnitude.
module sn_to_bn #(
  parameter int unsigned STREAM_LEN = 16,
  parameter int unsigned SKIP       = 0,
  parameter int unsigned CNT_W      = $clog2(STREAM_LEN + 1),
  parameter int unsigned OUT_W      = 4
) (
  input  logic             i_clk_sng,
  input  logic             i_rst_sng,
  input  logic             i_start_sng,
  input  logic             i_stop_sng,
  input  logic             i_sn_bit,
  output logic [CNT_W-1:0] o_cnt,
  output logic [OUT_W-1:0] o_bn,
  output logic             o_valid,
  output logic             o_busy
);

  localparam int unsigned SKIP_W    = 4;
  localparam int unsigned BN_MAX    = (1 << OUT_W) - 1;
  localparam int unsigned SKIP_LAST = (SKIP > 0) ? SKIP - 1 : 0;
  localparam logic [CNT_W-1:0]  LAST_SMP = CNT_W'(STREAM_LEN - 1);
  localparam logic [SKIP_W-1:0] SKIP_END = SKIP_W'(SKIP_LAST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SKIP = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // A fresh conversion skips the alignment phase entirely when SKIP is zero.
  localparam state_t START_ST = (SKIP > 0) ? S_SKIP : S_ACC;

  state_t            state_q;
  logic [CNT_W-1:0]  acc_q;
  logic [CNT_W-1:0]  smp_q;
  logic [SKIP_W-1:0] skip_q;
  logic [CNT_W-1:0]  cnt_fin_c;
  logic [OUT_W-1:0]  bn_sat_c;

  // Running count including the bit presented this cycle, and its saturated form.
  always_comb begin
    cnt_fin_c = acc_q + CNT_W'(i_sn_bit);
    bn_sat_c  = (32'(cnt_fin_c) > BN_MAX) ? OUT_W'(BN_MAX) : OUT_W'(cnt_fin_c);
  end

  // Conversion FSM with registered result, strobe and busy decode.
  always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
    if (i_rst_sng) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      smp_q   <= '0;
      skip_q  <= '0;
      o_cnt   <= '0;
      o_bn    <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_q)
        // DONE accepts a new start exactly like IDLE so conversions can chain.
        S_IDLE, S_DONE: begin
          if (i_start_sng) begin
            state_q <= START_ST;
            acc_q   <= '0;
            smp_q   <= '0;
            skip_q  <= '0;
            o_busy  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            o_busy  <= 1'b0;
          end
        end
        S_SKIP: begin
          if (i_stop_sng) begin
            state_q <= S_IDLE;
            o_busy  <= 1'b0;
          end else begin
            skip_q <= skip_q + SKIP_W'(1);
            if (skip_q == SKIP_END) begin
              state_q <= S_ACC;
            end
          end
        end
        S_ACC: begin
          if (i_stop_sng) begin
            state_q <= S_IDLE;
            o_busy  <= 1'b0;
          end else begin
            acc_q <= cnt_fin_c;
            smp_q <= smp_q + CNT_W'(1);
            if (smp_q == LAST_SMP) begin
              o_cnt   <= cnt_fin_c;
              o_bn    <= bn_sat_c;
              o_valid <= 1'b1;
              o_busy  <= 1'b0;
              state_q <= S_DONE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sn_to_bn.sv
// Directed bench for sn_to_bn: default instance plus a SKIP=2 instance.
module tb_sn_to_bn;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       sn;
  logic [4:0] cnt;
  logic [3:0] bn;
  logic       valid;
  logic       busy;

  logic       start2;
  logic       stop2;
  logic       sn2;
  logic [4:0] cnt2;
  logic [3:0] bn2;
  logic       valid2;
  logic       busy2;

  int checks;
  int failures;
  int cyc;
  int valid_cyc;

  sn_to_bn u_dut (
    .i_clk_sng   (clk),
    .i_rst_sng   (rst),
    .i_start_sng (start),
    .i_stop_sng  (stop),
    .i_sn_bit    (sn),
    .o_cnt       (cnt),
    .o_bn        (bn),
    .o_valid     (valid),
    .o_busy      (busy)
  );

  sn_to_bn #(.SKIP(2)) u_dut_skip (
    .i_clk_sng   (clk),
    .i_rst_sng   (rst),
    .i_start_sng (start2),
    .i_stop_sng  (stop2),
    .i_sn_bit    (sn2),
    .o_cnt       (cnt2),
    .o_bn        (bn2),
    .o_valid     (valid2),
    .o_busy      (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Start on the default instance, feed 16 bits MSB first, stop in the DONE cycle.
  task automatic convert(input logic [15:0] bits, input int start_at,
                         input logic [31:0] exp_cnt, input logic [31:0] exp_bn,
                         input string tag);
    int early;
    early = 0;
    start = 1'b1;
    sn    = 1'b0;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      sn    = bits[15-i];
      start = (i == start_at);
      tick();
      if (i < 15 && valid) early++;
    end
    start = 1'b0;
    sn    = 1'b0;
    valid_cyc = cyc;
    check({tag, "_early"}, 32'(early), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_cnt"}, 32'(cnt), exp_cnt);
    check({tag, "_bn"}, 32'(bn), exp_bn);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic pulse_end(input string tag);
    tick();
    check({tag, "_pulse"}, 32'(valid), 32'd0);
  endtask

  initial begin
    int v1;
    int seen;
    checks = 0; failures = 0; cyc = 0; valid_cyc = 0;
    start = 0; stop = 0; sn = 0;
    start2 = 0; stop2 = 0; sn2 = 0;
    rst = 1'b1;
    #3;
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_bn", 32'(bn), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #4 rst = 1'b0;
    tick();

    // All ones saturates the 4-bit output.
    convert(16'hFFFF, -1, 32'd16, 32'd15, "ones");
    pulse_end("ones");

    convert(16'h0000, -1, 32'd0, 32'd0, "zeros");
    pulse_end("zeros");

    convert(16'hFFFE, -1, 32'd15, 32'd15, "fifteen");
    pulse_end("fifteen");

    // Five ones, then back-to-back start from DONE.
    convert(16'b1010_0000_1001_0001, -1, 32'd5, 32'd5, "five");
    v1 = valid_cyc;
    convert(16'hFFFF, -1, 32'd16, 32'd15, "b2b");
    check("b2b_gap", 32'(valid_cyc - v1), 32'd17);
    pulse_end("b2b");

    // Abort at sample 9 after four ones, start raised simultaneously.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sn = (i < 4);
      tick();
    end
    sn = 1'b1; stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0; sn = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cnt", 32'(cnt), 32'd16);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid || busy) seen++;
    end
    check("abort_quiet", 32'(seen), 32'd0);
    check("abort_hold_bn", 32'(bn), 32'd15);

    // Start pulsed at sample 3 is ignored.
    convert(16'b0110_0110_0110_0110, 2, 32'd8, 32'd8, "nostart");
    pulse_end("nostart");

    // SKIP=2: leading two ones must be ignored.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    sn2 = 1'b1;
    tick();
    check("skip_busy", 32'(busy2), 32'd1);
    tick();
    sn2 = 1'b0;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i < 15 && valid2) seen++;
    end
    check("skip_early", 32'(seen), 32'd0);
    check("skip_valid", 32'(valid2), 32'd1);
    check("skip_cnt", 32'(cnt2), 32'd0);
    tick();
    check("skip_pulse", 32'(valid2), 32'd0);

    // Asynchronous reset mid-accumulation clears everything at once.
    start = 1'b1;
    tick();
    start = 1'b0;
    sn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_cnt", 32'(cnt), 32'd0);
    check("arst_bn", 32'(bn), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    sn = 1'b0;
    tick();
    convert(16'b1100_1100_1100_0000, -1, 32'd6, 32'd6, "post_rst");
    pulse_end("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
